// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: carries the decoded control bundle and operands into EX,
// inserts a bubble on load-use hazards, squashes on flush, and counts stall cycles.
module id_ex_stage_reg #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic            Branch,
    input  logic            MemRead,
    input  logic            MemtoReg,
    input  logic            MemWrite,
    input  logic            ALUSrc,
    input  logic            RegWrite,
    input  logic [1:0]      ALUOp,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic [2:0]      id_funct3,
    input  logic            id_funct7b5,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rd1,
    input  logic [XLEN-1:0] id_rd2,
    input  logic [XLEN-1:0] id_imm,
    input  logic            flush,
    output logic            ex_valid,
    output logic            ex_Branch,
    output logic            ex_MemRead,
    output logic            ex_MemtoReg,
    output logic            ex_MemWrite,
    output logic            ex_ALUSrc,
    output logic            ex_RegWrite,
    output logic [1:0]      ex_ALUOp,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [2:0]      ex_funct3,
    output logic            ex_funct7b5,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rd1,
    output logic [XLEN-1:0] ex_rd2,
    output logic [XLEN-1:0] ex_imm,
    output logic            stall,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef struct packed {
        logic       branch;
        logic       mem_read;
        logic       memto_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic [1:0] alu_op;
    } ctrl_t;

    ctrl_t id_ctrl;
    ctrl_t ex_ctrl;
    logic  hazard;
    logic  capture;

    // MemtoReg only matters when the instruction writes back; clearing it otherwise
    // keeps a don't-care from a store or branch out of EX.
    assign id_ctrl = '{
        branch:    Branch,
        mem_read:  MemRead,
        memto_reg: MemtoReg & RegWrite,
        mem_write: MemWrite,
        alu_src:   ALUSrc,
        reg_write: RegWrite,
        alu_op:    ALUOp
    };

    // rs2 is a true source only for register-register ops and stores.
    assign hazard = ex_valid && ex_ctrl.mem_read && (ex_rd != 5'd0) && id_valid &&
                    ((ex_rd == id_rs1) || ((ex_rd == id_rs2) && (!ALUSrc || MemWrite)));

    assign stall   = hazard && !flush;
    assign capture = !flush && !hazard;

    // NOTE: every sequential block uses <= so all registers sample pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
        end else begin
            ex_valid <= capture && id_valid;
            ex_ctrl  <= (capture && id_valid) ? id_ctrl : ctrl_t'('0);
        end
    end

    // Data fields hold across bubbles and flushes; only valid/controls are cleared.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_funct3   <= '0;
            ex_funct7b5 <= 1'b0;
            ex_pc       <= '0;
            ex_rd1      <= '0;
            ex_rd2      <= '0;
            ex_imm      <= '0;
        end else if (capture) begin
            ex_rs1      <= id_rs1;
            ex_rs2      <= id_rs2;
            ex_rd       <= id_rd;
            ex_funct3   <= id_funct3;
            ex_funct7b5 <= id_funct7b5;
            ex_pc       <= id_pc;
            ex_rd1      <= id_rd1;
            ex_rd2      <= id_rd2;
            ex_imm      <= id_imm;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign ex_Branch   = ex_ctrl.branch;
    assign ex_MemRead  = ex_ctrl.mem_read;
    assign ex_MemtoReg = ex_ctrl.memto_reg;
    assign ex_MemWrite = ex_ctrl.mem_write;
    assign ex_ALUSrc   = ex_ctrl.alu_src;
    assign ex_RegWrite = ex_ctrl.reg_write;
    assign ex_ALUOp    = ex_ctrl.alu_op;

endmodule
